// File: rtl/alu_share_arb.sv
// alu_share_arb
// Round-robin arbiter/sequencer sharing one combinational 3-bit ALU between
// two requesters. The winner's operands are latched onto the ALU ports, held
// for EXEC_CYCLES cycles, and the ALU result is captured and returned with a
// one-cycle ack pulse.
//
// Ports:
//   clk, rst                       clock (rising edge), async active-high reset
//   rN_req/rN_sel/rN_a/rN_b/rN_c   requester N request, op select, operands
//   alu_sel/alu_a/alu_b/alu_c      registered operands driven to the shared ALU
//   alu_d/alu_neg                  shared ALU result and negative flag
//   gnt                            one-hot owner, high during EXEC and RESP
//   ack                            one-cycle completion pulse to the owner
//   res_d/res_neg                  captured ALU result, held until next capture
//   busy                           high whenever the sequencer is not idle
//   op_cnt                         completed operations, wraps silently
module alu_share_arb #(
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_req,
  input  logic [1:0]       r0_sel,
  input  logic [2:0]       r0_a,
  input  logic [2:0]       r0_b,
  input  logic [2:0]       r0_c,
  input  logic             r1_req,
  input  logic [1:0]       r1_sel,
  input  logic [2:0]       r1_a,
  input  logic [2:0]       r1_b,
  input  logic [2:0]       r1_c,
  output logic [1:0]       alu_sel,
  output logic [2:0]       alu_a,
  output logic [2:0]       alu_b,
  output logic [2:0]       alu_c,
  input  logic [3:0]       alu_d,
  input  logic             alu_neg,
  output logic [1:0]       gnt,
  output logic [1:0]       ack,
  output logic [3:0]       res_d,
  output logic             res_neg,
  output logic             busy,
  output logic [CNT_W-1:0] op_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // Settle counter loads EXEC_CYCLES-1 so capture happens EXEC_CYCLES edges
  // after the grant edge.
  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t           state_q, state_d;
  logic             last_q, last_d;      // index of the previous owner
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       ack_q, ack_d;
  logic [3:0]       res_d_q, res_d_d;
  logic             res_neg_q, res_neg_d;
  logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
  logic [1:0]       alu_sel_q, alu_sel_d;
  logic [2:0]       alu_a_q, alu_a_d;
  logic [2:0]       alu_b_q, alu_b_d;
  logic [2:0]       alu_c_q, alu_c_d;

  // Arbitration: a lone requester wins; on a tie the one that did not own
  // the ALU last time wins. last_q resets to 1 so requester 0 wins first.
  logic win_valid;
  logic win_idx;

  always_comb begin
    win_valid = r0_req | r1_req;
    win_idx   = 1'b0;
    if (r0_req && r1_req) begin
      win_idx = ~last_q;
    end else if (r1_req) begin
      win_idx = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    ack_d     = 2'b00;                   // ack is a single-cycle pulse
    res_d_d   = res_d_q;
    res_neg_d = res_neg_q;
    op_cnt_d  = op_cnt_q;
    alu_sel_d = alu_sel_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_c_d   = alu_c_q;

    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          if (win_idx) begin
            alu_sel_d = r1_sel;
            alu_a_d   = r1_a;
            alu_b_d   = r1_b;
            alu_c_d   = r1_c;
            gnt_d     = 2'b10;
          end else begin
            alu_sel_d = r0_sel;
            alu_a_d   = r0_a;
            alu_b_d   = r0_b;
            alu_c_d   = r0_c;
            gnt_d     = 2'b01;
          end
          cnt_d   = CNT_INIT;
          state_d = EXEC;
        end
      end

      EXEC: begin
        // Requester inputs are deliberately not looked at here.
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          res_d_d   = alu_d;
          res_neg_d = alu_neg;
          ack_d     = gnt_q;
          op_cnt_d  = op_cnt_q + CNT_W'(1);
          last_d    = gnt_q[1];
          state_d   = RESP;
        end
      end

      RESP: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end

      default: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      cnt_q     <= 4'd0;
      gnt_q     <= 2'b00;
      ack_q     <= 2'b00;
      res_d_q   <= 4'd0;
      res_neg_q <= 1'b0;
      op_cnt_q  <= '0;
      alu_sel_q <= 2'd0;
      alu_a_q   <= 3'd0;
      alu_b_q   <= 3'd0;
      alu_c_q   <= 3'd0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      res_d_q   <= res_d_d;
      res_neg_q <= res_neg_d;
      op_cnt_q  <= op_cnt_d;
      alu_sel_q <= alu_sel_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_c_q   <= alu_c_d;
    end
  end

  assign alu_sel = alu_sel_q;
  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_c   = alu_c_q;
  assign gnt     = gnt_q;
  assign ack     = ack_q;
  assign res_d   = res_d_q;
  assign res_neg = res_neg_q;
  assign busy    = (state_q != IDLE);
  assign op_cnt  = op_cnt_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Testbench for alu_share_arb. Instance u_a uses default parameters;
// instance u_b uses EXEC_CYCLES=3, CNT_W=2. Each instance drives its own
// copy of the shared 3-bit ALU.
module tb_alu_share_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // The external shared ALU: returns {neg, d}.
  function automatic logic [4:0] alu_f(input logic [1:0] s, input logic [2:0] a,
                                       input logic [2:0] b, input logic [2:0] c);
    logic [4:0] r;
    case (s)
      2'd0: r = {1'b0, {1'b0, a} + {1'b0, b}};
      2'd1: r = (a < b) ? {1'b1, 1'b0, b - a} : {1'b0, 1'b0, a - b};
      2'd2: r = {1'b0, 1'b0, a ^ b ^ c};
      default: r = {1'b0, 1'b0, a & b & c};
    endcase
    return r;
  endfunction

  // ---------------- instance A (EXEC_CYCLES=1, CNT_W=8) ----------------
  logic       rst;
  logic       r0_req, r1_req;
  logic [1:0] r0_sel, r1_sel;
  logic [2:0] r0_a, r0_b, r0_c, r1_a, r1_b, r1_c;
  logic [1:0] alu_sel;
  logic [2:0] alu_a, alu_b, alu_c;
  logic [3:0] alu_d;
  logic       alu_neg;
  logic [1:0] gnt, ack;
  logic [3:0] res_d;
  logic       res_neg, busy;
  logic [7:0] op_cnt;

  assign {alu_neg, alu_d} = alu_f(alu_sel, alu_a, alu_b, alu_c);

  alu_share_arb u_a (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_sel(r0_sel), .r0_a(r0_a), .r0_b(r0_b), .r0_c(r0_c),
    .r1_req(r1_req), .r1_sel(r1_sel), .r1_a(r1_a), .r1_b(r1_b), .r1_c(r1_c),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .alu_d(alu_d), .alu_neg(alu_neg),
    .gnt(gnt), .ack(ack), .res_d(res_d), .res_neg(res_neg),
    .busy(busy), .op_cnt(op_cnt)
  );

  // ---------------- instance B (EXEC_CYCLES=3, CNT_W=2) ----------------
  logic       x_rst;
  logic       x_r0_req, x_r1_req;
  logic [1:0] x_r0_sel, x_r1_sel;
  logic [2:0] x_r0_a, x_r0_b, x_r0_c, x_r1_a, x_r1_b, x_r1_c;
  logic [1:0] x_alu_sel;
  logic [2:0] x_alu_a, x_alu_b, x_alu_c;
  logic [3:0] x_alu_d;
  logic       x_alu_neg;
  logic [1:0] x_gnt, x_ack;
  logic [3:0] x_res_d;
  logic       x_res_neg, x_busy;
  logic [1:0] x_op_cnt;

  assign {x_alu_neg, x_alu_d} = alu_f(x_alu_sel, x_alu_a, x_alu_b, x_alu_c);

  alu_share_arb #(.EXEC_CYCLES(3), .CNT_W(2)) u_b (
    .clk(clk), .rst(x_rst),
    .r0_req(x_r0_req), .r0_sel(x_r0_sel), .r0_a(x_r0_a), .r0_b(x_r0_b), .r0_c(x_r0_c),
    .r1_req(x_r1_req), .r1_sel(x_r1_sel), .r1_a(x_r1_a), .r1_b(x_r1_b), .r1_c(x_r1_c),
    .alu_sel(x_alu_sel), .alu_a(x_alu_a), .alu_b(x_alu_b), .alu_c(x_alu_c),
    .alu_d(x_alu_d), .alu_neg(x_alu_neg),
    .gnt(x_gnt), .ack(x_ack), .res_d(x_res_d), .res_neg(x_res_neg),
    .busy(x_busy), .op_cnt(x_op_cnt)
  );

  // All sampling and driving happens 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req_a(input int who, input logic [1:0] s, input logic [2:0] a,
                           input logic [2:0] b, input logic [2:0] c);
    if (who == 0) begin
      r0_req = 1'b1; r0_sel = s; r0_a = a; r0_b = b; r0_c = c;
    end else begin
      r1_req = 1'b1; r1_sel = s; r1_a = a; r1_b = b; r1_c = c;
    end
  endtask

  // Bounded wait for a grant on instance A; an expired bound shows gnt=0.
  task automatic wait_gnt_a(input string tag, input logic [1:0] exp);
    for (int i = 0; i < 20; i++) begin
      step();
      if (gnt != 2'b00) break;
    end
    $display("[TB] %s gnt=%b", tag, gnt);
    check(tag, gnt, exp);
  endtask

  // One op on instance A with EXEC_CYCLES=1: ack rises one edge after grant.
  task automatic op_a(input string tag, input int who, input logic [1:0] s,
                      input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                      input logic [3:0] exp_d, input logic exp_neg);
    logic [1:0] owner;
    owner = (who == 0) ? 2'b01 : 2'b10;
    set_req_a(who, s, a, b, c);
    wait_gnt_a({tag, "_gnt"}, owner);
    step();
    $display("[TB] %s ack=%b res_d=%0d res_neg=%0d", tag, ack, res_d, res_neg);
    check({tag, "_ack"}, ack, owner);
    check({tag, "_res_d"}, res_d, exp_d);
    check({tag, "_neg"}, res_neg, exp_neg);
    r0_req = 1'b0;
    r1_req = 1'b0;
    step();
    check({tag, "_idle"}, {ack, gnt, busy}, 5'b0);
  endtask

  // One op on instance B (EXEC_CYCLES=3): ack rises exactly 3 edges after the
  // grant edge. chg_a overwrites r0_a one cycle after the grant.
  task automatic op_b(input string tag, input int who, input logic [1:0] s,
                      input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                      input bit chg_a, input logic [3:0] exp_d, input logic [1:0] exp_cnt);
    logic [1:0] owner;
    int n;
    owner = (who == 0) ? 2'b01 : 2'b10;
    if (who == 0) begin
      x_r0_req = 1'b1; x_r0_sel = s; x_r0_a = a; x_r0_b = b; x_r0_c = c;
    end else begin
      x_r1_req = 1'b1; x_r1_sel = s; x_r1_a = a; x_r1_b = b; x_r1_c = c;
    end
    for (int i = 0; i < 20; i++) begin
      step();
      if (x_gnt != 2'b00) break;
    end
    check({tag, "_gnt"}, x_gnt, owner);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n++;
      if (chg_a && n == 1) x_r0_a = 3'd0;
      if (x_ack != 2'b00) break;
    end
    $display("[TB] %s lat=%0d ack=%b res_d=%0d op_cnt=%0d", tag, n, x_ack, x_res_d, x_op_cnt);
    check({tag, "_lat"}, n, 3);
    check({tag, "_ack"}, x_ack, owner);
    check({tag, "_res_d"}, x_res_d, exp_d);
    check({tag, "_op_cnt"}, x_op_cnt, exp_cnt);
    x_r0_req = 1'b0;
    x_r1_req = 1'b0;
    step();
    check({tag, "_idle"}, x_busy, 1'b0);
  endtask

  initial begin
    int k, prev;
    logic [1:0] exp_own;
    rst = 1'b1; x_rst = 1'b1;
    r0_req = 0; r0_sel = 0; r0_a = 0; r0_b = 0; r0_c = 0;
    r1_req = 0; r1_sel = 0; r1_a = 0; r1_b = 0; r1_c = 0;
    x_r0_req = 0; x_r0_sel = 0; x_r0_a = 0; x_r0_b = 0; x_r0_c = 0;
    x_r1_req = 0; x_r1_sel = 0; x_r1_a = 0; x_r1_b = 0; x_r1_c = 0;
    step();
    step();
    check("rst_outs", {gnt, ack, res_d, res_neg, busy, op_cnt}, 0);
    check("rst_alu", {alu_sel, alu_a, alu_b, alu_c}, 0);
    rst = 1'b0; x_rst = 1'b0;

    // Single op: 2+5.
    set_req_a(0, 2'd0, 3'd2, 3'd5, 3'd0);
    step();
    $display("[TB] single gnt=%b busy=%0d alu_a=%0d alu_b=%0d", gnt, busy, alu_a, alu_b);
    check("single_gnt", gnt, 2'b01);
    check("single_busy", busy, 1'b1);
    check("single_alu_ops", {alu_a, alu_b}, {3'd2, 3'd5});
    step();
    $display("[TB] single ack=%b res_d=%0d op_cnt=%0d", ack, res_d, op_cnt);
    check("single_ack", ack, 2'b01);
    check("single_res_d", res_d, 4'd7);
    check("single_neg", res_neg, 1'b0);
    check("single_op_cnt", op_cnt, 8'd1);
    check("single_gnt_resp", gnt, 2'b01);
    r0_req = 1'b0;
    step();
    check("single_end", {ack, gnt, busy}, 5'b0);

    // Subtracts on requester 1.
    op_a("sub_neg", 1, 2'd1, 3'd4, 3'd7, 3'd0, 4'd3, 1'b1);
    op_a("sub_pos", 1, 2'd1, 3'd6, 3'd2, 3'd0, 4'd4, 1'b0);

    // Both requesting continuously: r0 -> 4^6^5=7, r1 -> 7&6&4=4.
    set_req_a(0, 2'd2, 3'd4, 3'd6, 3'd5);
    set_req_a(1, 2'd3, 3'd7, 3'd6, 3'd4);
    k = 0;
    prev = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      step();
      if (ack != 2'b00 && k < 4) begin
        exp_own = (k % 2 == 0) ? 2'b01 : 2'b10;
        $display("[TB] rr ack#%0d cyc=%0d ack=%b res_d=%0d", k, cyc, ack, res_d);
        check("rr_owner", ack, exp_own);
        check("rr_res_d", res_d, (k % 2 == 0) ? 4'd7 : 4'd4);
        if (k > 0) check("rr_spacing", cyc - prev, 3);
        prev = cyc;
        k++;
      end
    end
    check("rr_ack_count", k, 4);
    r0_req = 1'b0;
    r1_req = 1'b0;
    repeat (3) step();
    check("rr_idle", busy, 1'b0);

    // Reset during EXEC of r1 (7+7), then both request.
    set_req_a(1, 2'd0, 3'd7, 3'd7, 3'd0);
    wait_gnt_a("rstmid_gnt", 2'b10);
    #2 rst = 1'b1;
    #1;
    check("rstmid_outs", {gnt, ack, res_d, res_neg, busy, op_cnt}, 0);
    check("rstmid_alu", {alu_sel, alu_a, alu_b, alu_c}, 0);
    set_req_a(0, 2'd0, 3'd7, 3'd7, 3'd0);
    step();
    check("rstmid_no_ack", ack, 2'b00);
    rst = 1'b0;
    wait_gnt_a("rstmid_prio", 2'b01);
    step();
    $display("[TB] rstmid ack=%b res_d=%0d op_cnt=%0d", ack, res_d, op_cnt);
    check("rstmid_ack", ack, 2'b01);
    check("rstmid_res_d", res_d, 4'd14);
    check("rstmid_op_cnt", op_cnt, 8'd1);
    r0_req = 1'b0;
    r1_req = 1'b0;
    repeat (3) step();

    // Instance B: operand change during EXEC (3&2&7=2), then counter wrap.
    op_b("opchg", 0, 2'd3, 3'd3, 3'd2, 3'd7, 1'b1, 4'd2, 2'd1);
    op_b("wrap2", 1, 2'd0, 3'd1, 3'd1, 3'd0, 1'b0, 4'd2, 2'd2);
    op_b("wrap3", 0, 2'd0, 3'd1, 3'd2, 3'd0, 1'b0, 4'd3, 2'd3);
    op_b("wrap0", 1, 2'd0, 3'd3, 3'd3, 3'd0, 1'b0, 4'd6, 2'd0);
    op_b("wrap1", 0, 2'd2, 3'd1, 3'd2, 3'd4, 1'b0, 4'd7, 2'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
